// File: rtl/seg_scan_if.sv
// Bus between display registers and the seven-segment scan driver.
// The datapath side is the master; the scan driver is the slave.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic                hex_mode;
  logic                lzb_en;
  logic [DIGITS-1:0]   blink_mask;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   dig_n;

  modport master (
    output data_in, load, dp_in, hex_mode, lzb_en, blink_mask,
    input  seg_n, dp_n, dig_n
  );

  modport slave (
    input  data_in, load, dp_in, hex_mode, lzb_en, blink_mask,
    output seg_n, dp_n, dig_n
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed nibble word,
// hex/decimal decode, leading-zero blanking, per-digit blink and decimal points.
module seg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SHD_W = 4 * DIGITS;

  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;
  logic [SHD_W-1:0]  shd;
  logic [FRM_W-1:0]  frm;
  logic              bph;

  logic              tick_c;
  logic              frame_end_c;
  logic [3:0]        nib_c;
  logic              dp_c;
  logic              bm_c;
  logic              zf_c;
  logic [DIGITS-1:0] zero_from_c;
  logic              lzb_c;
  logic              blink_c;
  logic [6:0]        pat_c;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    if (!hex && (n > 4'd9)) p = 7'h00;
    return p;
  endfunction

  assign tick_c      = (pre == PRE_W'(DIV - 1));
  assign frame_end_c = tick_c && (idx == IDX_W'(DIGITS - 1));

  // zero_from_c[i] is set when nibbles i..DIGITS-1 of the shadow are all zero
  always_comb begin
    logic run;
    zero_from_c = '0;
    run         = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      run            = run && (shd[4*i +: 4] == 4'd0);
      zero_from_c[i] = run;
    end
  end

  // Per-digit selection for the digit currently being driven
  always_comb begin
    nib_c = '0;
    dp_c  = 1'b0;
    bm_c  = 1'b0;
    zf_c  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        nib_c = shd[4*i +: 4];
        dp_c  = bus.dp_in[i];
        bm_c  = bus.blink_mask[i];
        zf_c  = zero_from_c[i];
      end
    end
  end

  assign lzb_c   = bus.lzb_en && zf_c && (idx != '0);
  assign blink_c = bph && bm_c;
  assign pat_c   = decode(nib_c, bus.hex_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      idx       <= '0;
      shd       <= '0;
      frm       <= '0;
      bph       <= 1'b0;
      bus.seg_n <= 7'h7F;
      bus.dp_n  <= 1'b1;
      bus.dig_n <= '1;
    end else begin
      pre <= tick_c ? '0 : pre + PRE_W'(1);
      if (tick_c) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
      // Blink phase advances once per BLINK_FRAMES complete frames
      if (frame_end_c) begin
        if (frm == FRM_W'(BLINK_FRAMES - 1)) begin
          frm <= '0;
          bph <= ~bph;
        end else begin
          frm <= frm + FRM_W'(1);
        end
      end
      if (bus.load) shd <= bus.data_in;
      bus.dig_n <= ~(DIGITS'(1) << idx);
      bus.seg_n <= (lzb_c || blink_c) ? 7'h7F : ~pat_c;
      bus.dp_n  <= blink_c ? 1'b1 : ~dp_c;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, DIV=4, BLINK_FRAMES=2.
// Edge k counts rising edges since reset release; digit shown after edge k is ((k-1)/4)%4.
module tb_seg_scan_driver;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned BF     = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(DIGITS)) bus();

  seg_scan_driver #(
    .DIGITS(DIGITS),
    .DIV(DIV),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Edges seen since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input string tag, input logic [6:0] seg, input logic dp,
                          input logic [3:0] dig);
    exp_t e;
    e.tag = tag;
    e.seg = seg;
    e.dp  = dp;
    e.dig = dig;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      failures++;
      $display("FAIL wait_edge cyc=%0d required=%0d", cyc, k);
    end
  endtask

  task automatic compare();
    exp_t       e;
    logic [11:0] obs;
    logic [11:0] req;
    e   = sb.pop_front();
    obs = {bus.seg_n, bus.dp_n, bus.dig_n};
    req = {e.seg, e.dp, e.dig};
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed seg_n=%h dp_n=%b dig_n=%b expected seg_n=%h dp_n=%b dig_n=%b",
             e.tag, bus.seg_n, bus.dp_n, bus.dig_n, e.seg, e.dp, e.dig);
    end
  endtask

  task automatic check_at(input int k, input string tag, input logic [6:0] seg,
                          input logic dp, input logic [3:0] dig);
    push_exp(tag, seg, dp, dig);
    wait_edge(k);
    compare();
  endtask

  task automatic check_now(input string tag, input logic [6:0] seg, input logic dp,
                           input logic [3:0] dig);
    push_exp(tag, seg, dp, dig);
    compare();
  endtask

  task automatic load_at(input int k, input logic [15:0] val);
    wait_edge(k - 1);
    bus.data_in = val;
    bus.load    = 1'b1;
    wait_edge(k);
    bus.load    = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.data_in    = '0;
    bus.load       = 1'b0;
    bus.dp_in      = '0;
    bus.hex_mode   = 1'b1;
    bus.lzb_en     = 1'b0;
    bus.blink_mask = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_now("reset", 7'h7F, 1'b1, 4'hF);

    // Scan order and hex decode of 0x1234
    rst_n = 1'b1;
    load_at(1, 16'h1234);
    check_at(1,  "first_edge", 7'h40, 1'b1, 4'b1110);
    check_at(2,  "scan_d0",    7'h19, 1'b1, 4'b1110);
    check_at(5,  "scan_d1",    7'h30, 1'b1, 4'b1101);
    check_at(9,  "scan_d2",    7'h24, 1'b1, 4'b1011);
    check_at(13, "scan_d3",    7'h79, 1'b1, 4'b0111);

    // Hex versus decimal with 0x00AF
    load_at(17, 16'h00AF);
    check_at(17, "scan_wrap",  7'h19, 1'b1, 4'b1110);
    check_at(18, "hex_F",      7'h0E, 1'b1, 4'b1110);
    check_at(21, "hex_A",      7'h08, 1'b1, 4'b1101);
    check_at(25, "hex_d2_0",   7'h40, 1'b1, 4'b1011);
    check_at(29, "hex_d3_0",   7'h40, 1'b1, 4'b0111);
    wait_edge(32);
    bus.hex_mode = 1'b0;
    check_at(33, "dec_F",      7'h7F, 1'b1, 4'b1110);
    check_at(37, "dec_A",      7'h7F, 1'b1, 4'b1101);

    // Leading-zero blanking
    wait_edge(40);
    bus.hex_mode = 1'b1;
    bus.lzb_en   = 1'b1;
    load_at(41, 16'h0050);
    check_at(45, "lzb_d3",     7'h7F, 1'b1, 4'b0111);
    check_at(49, "lzb_d0",     7'h40, 1'b1, 4'b1110);
    check_at(53, "lzb_d1",     7'h12, 1'b1, 4'b1101);
    bus.dp_in = 4'b0100;
    check_at(57, "lzb_dp",     7'h7F, 1'b0, 4'b1011);
    bus.dp_in = 4'b0000;
    load_at(58, 16'h0000);
    check_at(61, "lzb0_d3",    7'h7F, 1'b1, 4'b0111);
    check_at(65, "lzb0_d0",    7'h40, 1'b1, 4'b1110);
    check_at(69, "lzb0_d1",    7'h7F, 1'b1, 4'b1101);
    bus.lzb_en = 1'b0;

    // Load on the same edge as the tick into digit 2
    load_at(72, 16'h9999);
    check_at(72, "pre_collide", 7'h40, 1'b1, 4'b1101);
    check_at(73, "collide",     7'h10, 1'b1, 4'b1011);

    // Asynchronous reset between edges while digit 2 is shown
    #2 rst_n = 1'b0;
    #1 check_now("async_rst", 7'h7F, 1'b1, 4'hF);
    bus.blink_mask = 4'b0001;
    bus.dp_in      = 4'b0001;
    @(negedge clk);
    check_now("rst_hold", 7'h7F, 1'b1, 4'hF);
    rst_n = 1'b1;

    // Blink of digit 0 over a fresh timeline
    load_at(1, 16'h0008);
    check_at(1,  "rel_first",  7'h40, 1'b0, 4'b1110);
    check_at(2,  "blk_on_a",   7'h00, 1'b0, 4'b1110);
    check_at(4,  "blk_on_b",   7'h00, 1'b0, 4'b1110);
    check_at(32, "blk_d3_a",   7'h40, 1'b1, 4'b0111);
    check_at(33, "blk_off_a",  7'h7F, 1'b1, 4'b1110);
    check_at(36, "blk_off_b",  7'h7F, 1'b1, 4'b1110);
    check_at(37, "blk_d1",     7'h40, 1'b1, 4'b1101);
    check_at(64, "blk_d3_b",   7'h40, 1'b1, 4'b0111);
    check_at(65, "blk_on_c",   7'h00, 1'b0, 4'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the board's multi-digit common-anode displays. It latches a packed nibble word, decodes each nibble (hex or decimal mode), and scans one digit per time slot. Per-digit decimal points, leading-zero blanking and per-digit blinking are supported. It sits between datapath/display registers and the board's segment and digit-select pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `DIV`, 50000: clocks per digit slot; must be ≥2.
- `BLINK_FRAMES`, 25: full scan frames per blink half-period; must be ≥1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `data_in`  in  4*DIGITS  packed nibbles; nibble i is `data_in[4i+3:4i]`, digit 0 is rightmost.
- `load`  in  1  when high at a clock edge, `data_in` is captured into the shadow register.
- `dp_in`  in  DIGITS  decimal point request per digit, active-high; sampled live, not shadowed.
- `hex_mode`  in  1  1 = nibbles 0-F shown as 0-9,A,b,C,d,E,F; 0 = decimal, nibbles 10-15 blank.
- `lzb_en`  in  1  leading-zero blanking enable.
- `blink_mask`  in  DIGITS  per-digit blink enable.
- `seg_n`  out  7  segments g..a (bit0 = a), active-low.
- `dp_n`  out  1  decimal point, active-low.
- `dig_n`  out  DIGITS  digit enables, active-low, one-hot-low while running.

## Operation
- State: prescaler `pre` (0..DIV-1), digit index `idx` (0..DIGITS-1), shadow register `shd` (4*DIGITS), frame counter `frm` (0..BLINK_FRAMES-1), blink phase `bph`.
- Prescaler increments every clock. `tick` is asserted when `pre == DIV-1`; on `tick`, `pre` wraps to 0.
- On `tick`, `idx` increments, wrapping from DIGITS-1 to 0.
- On a `tick` that wraps `idx` to 0 (frame end), `frm` increments. When `frm` wraps from BLINK_FRAMES-1 to 0, `bph` toggles.
- `load`: `shd <= data_in`. It has no effect on `pre`, `idx` or the blink state.
- Segment decode uses active-high gfedcba patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - In decimal mode, nibbles 10-15 decode to 00.
- Leading-zero blank for digit i (i ≥ 1): `lzb_en` is set and nibbles i..DIGITS-1 of `shd` are all 0.
  - Digit 0 is never LZB-blanked.
  - LZB blanks segments only; `dp` is still driven from `dp_in`.
- Blink blank for digit i: `bph == 1` and `blink_mask[i]`. Blink blanks both segments and dp.
- Registered outputs for current digit i = `idx`:
  - `dig_n = ~(1<<i)`.
  - `seg_n = ~pattern`, or 7'h7F if the digit is blanked.
  - `dp_n = ~dp_in[i]`, or 1 if blink-blanked.

## Timing
- Reset (async, immediate, no clock needed):
  - `pre`, `idx`, `frm`, `bph` = 0; `shd` = 0.
  - `seg_n` = 7'h7F, `dp_n` = 1, `dig_n` = all ones.
- Outputs are registered from the state registers and the live inputs, with a one-clock lag.
  - The first rising edge after reset release drives digit 0 with `shd = 0`: `dig_n = ~1`, `seg_n = 7'h40`.
- Digit slot length is exactly DIV clocks. A full frame is DIGITS*DIV clocks. A blink half-period is BLINK_FRAMES*DIGITS*DIV clocks.
- `load` at edge E updates `shd` at E. Outputs reflect the new value at E+1, provided the affected digit is displayed at E+1.
- `load` and `tick` at the same edge: both take effect. The output at E+1 shows the new `idx` with the new `shd`.
- `hex_mode`, `lzb_en`, `blink_mask` and `dp_in` changes are visible at the next edge; no resynchronisation is performed.
- DIGITS = 1: `idx` stays 0, every `tick` is a frame end, and `dig_n` is permanently 0 after reset.
- Reset asserted mid-scan: all state clears at once. After release, scanning restarts at digit 0 with `pre = 0`.

## Test plan
Bench parameters: DIGITS=4, DIV=4, BLINK_FRAMES=2.
- **Reset/scan.** Hold rst_n low → seg_n=7F, dp_n=1, dig_n=F. Release, then load 0x1234 with hex_mode=1 → digit 0 slot shows dig_n=1110, seg_n=19. The next slot, 4 clocks later, shows dig_n=1101, seg_n=30. Slot order is 0,1,2,3,0.
- **Hex vs decimal.** Load 0x00AF. With hex_mode=1 → digit 0 seg_n=0E, digit 1 seg_n=08. With hex_mode=0 → both 7F. Digits 2-3 show 40 (lzb_en=0).
- **LZB.** lzb_en=1, load 0x0050 → digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40. With dp_in=0100 → dp_n=0 during the blanked digit 2 slot. Load 0x0000 → only digit 0 lit, seg_n=40.
- **Blink.** blink_mask=0001, data 0x0008 → digit 0 shows 00 for the first 32 clocks after reset, 7F with dp_n=1 for the next 32, then 00 again. Other digits are unaffected.
- **Load collision.** Assert load with 0x9999 on the same edge as a tick into digit 2 → at the next edge dig_n=1011, seg_n=10. No stale value appears.
- **Async reset mid-scan.** While idx=2, drop rst_n between edges → outputs go to 7F/1/F before the next edge. After release, the first edge gives dig_n=1110, seg_n=40.
